data_unpacker: RTL and testbench

Splits a block of four 64-bit words into eight 32-bit words and streams them out one per transfer over a valid/ready handshake. Sits on the return path opposite the 32→64 packing converter. It restores the original 32-bit word sequence from packed 64-bit data before the data goes to 32-bit consumers such as the phasor/sample processing stages.

---
 rtl/data_unpacker.sv | 99 +++++++++
 tb/tb_data_unpacker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_unpacker.sv
// Splits a block of four 64-bit words into eight 32-bit words and streams them
// out over a valid/ready handshake, restoring the pre-packing word order.
module data_unpacker #(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        LOAD,
  input  logic [63:0] DIN [3:0],
  output logic        BUSY,
  output logic [31:0] DOUT,
  output logic        DVALID,
  input  logic        DREADY,
  output logic [2:0]  IDX,
  output logic        UNPK_END
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [63:0] hold_q [3:0];
  logic [63:0] hold_d [3:0];
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] dout_q, dout_d;
  logic        dvalid_q, dvalid_d;
  logic        busy_q, busy_d;
  logic        end_q, end_d;

  // Word k lives in 64-bit word k>>1; k[0] picks the half, order set by HI_FIRST.
  function automatic logic [31:0] sel_half(input logic [63:0] w, input logic odd);
    logic hi;
    hi = HI_FIRST ? ~odd : odd;
    return hi ? w[63:32] : w[31:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    busy_d   = busy_q;
    end_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (LOAD) begin
          hold_d   = DIN;
          cnt_d    = 3'd0;
          dout_d   = sel_half(DIN[0], 1'b0);
          dvalid_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (DREADY) begin
          if (cnt_q == 3'd7) begin
            cnt_d    = 3'd0;
            dvalid_d = 1'b0;
            busy_d   = 1'b0;
            end_d    = 1'b1;
            state_d  = StIdle;
          end else begin
            cnt_d  = cnt_q + 3'd1;
            dout_d = sel_half(hold_q[cnt_d[2:1]], cnt_d[0]);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= StIdle;
      hold_q   <= '{default: '0};
      cnt_q    <= 3'd0;
      dout_q   <= 32'h0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      end_q    <= end_d;
    end
  end

  assign BUSY     = busy_q;
  assign DOUT     = dout_q;
  assign DVALID   = dvalid_q;
  assign IDX      = cnt_q;
  assign UNPK_END = end_q;

endmodule

// File: tb/tb_data_unpacker.sv
// Directed bench for data_unpacker: one HI_FIRST=1 and one HI_FIRST=0 instance
// share all inputs.
module tb_data_unpacker;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        LOAD;
  logic [63:0] DIN [3:0];
  logic        DREADY;

  logic        busy_h, dvalid_h, end_h;
  logic [31:0] dout_h;
  logic [2:0]  idx_h;
  logic        busy_l, dvalid_l, end_l;
  logic [31:0] dout_l;
  logic [2:0]  idx_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  data_unpacker #(.HI_FIRST(1'b1)) u_dut_hi (
    .CLK(CLK), .nRST(nRST), .LOAD(LOAD), .DIN(DIN), .BUSY(busy_h), .DOUT(dout_h),
    .DVALID(dvalid_h), .DREADY(DREADY), .IDX(idx_h), .UNPK_END(end_h)
  );

  data_unpacker #(.HI_FIRST(1'b0)) u_dut_lo (
    .CLK(CLK), .nRST(nRST), .LOAD(LOAD), .DIN(DIN), .BUSY(busy_l), .DOUT(dout_l),
    .DVALID(dvalid_l), .DREADY(DREADY), .IDX(idx_l), .UNPK_END(end_l)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_blk_a();
    DIN[0] = 64'h00000000_11111111;
    DIN[1] = 64'h22222222_33333333;
    DIN[2] = 64'h44444444_55555555;
    DIN[3] = 64'h66666666_77777777;
  endtask

  task automatic set_blk_b();
    DIN[0] = 64'hDEADBEEF_DEADBEEF;
    DIN[1] = 64'hDEADBEEF_DEADBEEF;
    DIN[2] = 64'hDEADBEEF_DEADBEEF;
    DIN[3] = 64'hDEADBEEF_DEADBEEF;
  endtask

  task automatic set_blk_c();
    DIN[0] = 64'hCAFE0001_CAFE0002;
    DIN[1] = 64'hCAFE0003_CAFE0004;
    DIN[2] = 64'hCAFE0005_CAFE0006;
    DIN[3] = 64'hCAFE0007_CAFE0008;
  endtask

  // Block A word k is k * 0x11111111 in HI_FIRST=1 order.
  function automatic logic [31:0] exp_a(input int k);
    return 32'h11111111 * k;
  endfunction

  initial begin
    int e;
    int cyc;
    int ends;
    logic [2:0] pat;

    // Reset with LOAD held high
    nRST = 1'b0; LOAD = 1'b1; DREADY = 1'b1; set_blk_a();
    tick(); tick();
    check_eq("rst_busy", busy_h, 0);
    check_eq("rst_dvalid", dvalid_h, 0);
    check_eq("rst_end", end_h, 0);
    check_eq("rst_dout", dout_h, 0);
    check_eq("rst_idx", idx_h, 0);
    nRST = 1'b1; LOAD = 1'b0;
    tick();
    check_eq("rst_nocap_dvalid", dvalid_h, 0);
    check_eq("rst_nocap_busy", busy_h, 0);

    // Basic order on both instances
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("basic_dout%0d", k), dout_h, exp_a(k));
      check_eq($sformatf("basic_idx%0d", k), idx_h, k);
      check_eq($sformatf("basic_valid%0d", k), dvalid_h, 1);
      check_eq($sformatf("basic_busy%0d", k), busy_h, 1);
      check_eq($sformatf("basic_end%0d", k), end_h, 0);
      check_eq($sformatf("lofirst_dout%0d", k), dout_l, exp_a(k ^ 1));
      tick();
    end
    check_eq("basic_end_pulse", end_h, 1);
    check_eq("basic_end_busy", busy_h, 0);
    check_eq("basic_end_valid", dvalid_h, 0);
    check_eq("lofirst_end_pulse", end_l, 1);
    tick();
    check_eq("basic_end_fall", end_h, 0);

    // Backpressure: DREADY pattern 1,0,0 repeating
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    e = 0; cyc = 0; ends = 0;
    pat = 3'b001;
    while (e < 8 && cyc < 40) begin
      check_eq($sformatf("bp_dout_c%0d", cyc), dout_h, exp_a(e));
      check_eq($sformatf("bp_idx_c%0d", cyc), idx_h, e);
      check_eq($sformatf("bp_valid_c%0d", cyc), dvalid_h, 1);
      if (end_h) ends++;
      DREADY = pat[cyc % 3];
      if (DREADY) e++;
      tick();
      cyc++;
    end
    check_eq("bp_transfers", e, 8);
    check_eq("bp_end_pulse", end_h, 1);
    check_eq("bp_end_valid", dvalid_h, 0);
    ends += end_h ? 1 : 0;
    DREADY = 1'b1;
    tick();
    ends += end_h ? 1 : 0;
    check_eq("bp_end_once", ends, 1);

    // Ignored LOAD with new DIN at IDX=3, then back-to-back LOAD in end cycle
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("ign_dout%0d", k), dout_h, exp_a(k));
      check_eq($sformatf("ign_idx%0d", k), idx_h, k);
      if (k == 3) begin
        LOAD = 1'b1;
        set_blk_b();
      end else begin
        LOAD = 1'b0;
      end
      tick();
    end
    check_eq("ign_end_pulse", end_h, 1);
    check_eq("ign_end_busy", busy_h, 0);
    LOAD = 1'b1;
    set_blk_c();
    tick();
    LOAD = 1'b0;
    set_blk_a();
    check_eq("b2b_valid", dvalid_h, 1);
    check_eq("b2b_idx", idx_h, 0);
    check_eq("b2b_dout", dout_h, 32'hCAFE0001);
    check_eq("b2b_end_fall", end_h, 0);
    check_eq("b2b_lo_dout", dout_l, 32'hCAFE0002);
    tick();
    check_eq("b2b_dout1", dout_h, 32'hCAFE0002);
    check_eq("b2b_lo_dout1", dout_l, 32'hCAFE0001);
    tick(); tick(); tick();
    check_eq("b2b_idx4", idx_h, 4);
    tick();

    // Reset mid-block at IDX=5
    check_eq("mid_idx5", idx_h, 5);
    check_eq("mid_dout5", dout_h, 32'hCAFE0006);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    check_eq("mid_rst_valid", dvalid_h, 0);
    check_eq("mid_rst_busy", busy_h, 0);
    check_eq("mid_rst_end", end_h, 0);
    check_eq("mid_rst_dout", dout_h, 0);
    ends = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      ends += end_h ? 1 : 0;
    end
    check_eq("mid_no_end", ends, 0);
    check_eq("mid_idle_valid", dvalid_h, 0);
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("fresh_dout%0d", k), dout_h, exp_a(k));
      check_eq($sformatf("fresh_idx%0d", k), idx_h, k);
      tick();
    end
    check_eq("fresh_end_pulse", end_h, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
